// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external SIZE-bit D-flip-flop shift chain: accepts a word, loads the chain, shifts it out MSB-first.
// Optional feature macro: SHIFT_SEQ_CTRL_PARITY_EN appends an even-parity bit after the last data bit.
module shift_seq_ctrl #(
    parameter  int unsigned SIZE  = 16,
    localparam int unsigned CNT_W = $clog2(SIZE)
) (
    input  logic            shift_seq_ctrl_port_clk,
    input  logic            shift_seq_ctrl_port_rst,
    input  logic            shift_seq_ctrl_port_in_valid,
    output logic            shift_seq_ctrl_port_in_ready,
    input  logic [SIZE-1:0] shift_seq_ctrl_port_in_data,
    input  logic            shift_seq_ctrl_port_hold,
    output logic            shift_seq_ctrl_port_sr_en,
    output logic            shift_seq_ctrl_port_sr_sp,
    output logic            shift_seq_ctrl_port_sr_si,
    output logic [SIZE-1:0] shift_seq_ctrl_port_sr_pi,
    input  logic            shift_seq_ctrl_port_sr_q,
    output logic            shift_seq_ctrl_port_ser_out,
    output logic            shift_seq_ctrl_port_ser_valid,
    output logic            shift_seq_ctrl_port_busy,
    output logic            shift_seq_ctrl_port_done
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        PAR   = 3'd4,
`endif
        DONE  = 3'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SIZE-1:0]  word_q;
    logic             accept;

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    logic             parity_q;
`endif

    assign accept = shift_seq_ctrl_port_in_valid && (state == IDLE);

    // State, bit counter and the captured word
    always_ff @(posedge shift_seq_ctrl_port_clk or negedge shift_seq_ctrl_port_rst) begin
        if (!shift_seq_ctrl_port_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            word_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                word_q <= shift_seq_ctrl_port_in_data;
            end
        end
    end

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    // Even parity of the accepted word, sent after the last data bit
    always_ff @(posedge shift_seq_ctrl_port_clk or negedge shift_seq_ctrl_port_rst) begin
        if (!shift_seq_ctrl_port_rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^shift_seq_ctrl_port_in_data;
        end
    end
`endif

    // Next-state and counter; hold only freezes the shifting states
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!shift_seq_ctrl_port_hold) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            PAR: begin
                if (!shift_seq_ctrl_port_hold) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control outputs decoded from the state so reset takes effect in the same cycle
    always_comb begin
        shift_seq_ctrl_port_in_ready  = 1'b0;
        shift_seq_ctrl_port_sr_en     = 1'b0;
        shift_seq_ctrl_port_sr_sp     = 1'b1;
        shift_seq_ctrl_port_ser_out   = 1'b0;
        shift_seq_ctrl_port_ser_valid = 1'b0;
        shift_seq_ctrl_port_done      = 1'b0;
        case (state)
            IDLE: begin
                shift_seq_ctrl_port_in_ready = 1'b1;
            end
            LOAD: begin
                shift_seq_ctrl_port_sr_en = 1'b1;
                shift_seq_ctrl_port_sr_sp = 1'b0;
            end
            SHIFT: begin
                shift_seq_ctrl_port_ser_out   = shift_seq_ctrl_port_sr_q;
                shift_seq_ctrl_port_ser_valid = !shift_seq_ctrl_port_hold;
                shift_seq_ctrl_port_sr_en     = !shift_seq_ctrl_port_hold;
            end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            PAR: begin
                shift_seq_ctrl_port_ser_out   = parity_q;
                shift_seq_ctrl_port_ser_valid = !shift_seq_ctrl_port_hold;
            end
`endif
            DONE: begin
                shift_seq_ctrl_port_done = 1'b1;
            end
            default: begin
                shift_seq_ctrl_port_in_ready = 1'b0;
            end
        endcase
    end

    assign shift_seq_ctrl_port_busy  = (state != IDLE);
    assign shift_seq_ctrl_port_sr_si = 1'b0;
    assign shift_seq_ctrl_port_sr_pi = word_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl (SIZE = 8) driving a behavioural shift chain; scoreboard of expected serial bits.
module tb_shift_seq_ctrl;

    localparam int unsigned SIZE = 8;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    localparam int unsigned NBITS = SIZE + 1;
`else
    localparam int unsigned NBITS = SIZE;
`endif
    localparam int DONE_CYC = int'(NBITS) + 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic            hold;
    logic            sr_en;
    logic            sr_sp;
    logic            sr_si;
    logic [SIZE-1:0] sr_pi;
    logic            sr_q;
    logic            ser_out;
    logic            ser_valid;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] chain;

    int   total = 0;
    int   bad   = 0;
    logic sb[$];

    always #5 clk = ~clk;

    shift_seq_ctrl #(.SIZE(SIZE)) dut (
        .shift_seq_ctrl_port_clk      (clk),
        .shift_seq_ctrl_port_rst      (rst_n),
        .shift_seq_ctrl_port_in_valid (in_valid),
        .shift_seq_ctrl_port_in_ready (in_ready),
        .shift_seq_ctrl_port_in_data  (in_data),
        .shift_seq_ctrl_port_hold     (hold),
        .shift_seq_ctrl_port_sr_en    (sr_en),
        .shift_seq_ctrl_port_sr_sp    (sr_sp),
        .shift_seq_ctrl_port_sr_si    (sr_si),
        .shift_seq_ctrl_port_sr_pi    (sr_pi),
        .shift_seq_ctrl_port_sr_q     (sr_q),
        .shift_seq_ctrl_port_ser_out  (ser_out),
        .shift_seq_ctrl_port_ser_valid(ser_valid),
        .shift_seq_ctrl_port_busy     (busy),
        .shift_seq_ctrl_port_done     (done)
    );

    // External parallel-in / serial-out chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else if (sr_en) begin
            chain <= sr_sp ? {chain[SIZE-2:0], sr_si} : sr_pi;
        end
    end
    assign sr_q = chain[SIZE-1];

    task automatic push_word(input logic [SIZE-1:0] w);
        for (int i = int'(SIZE) - 1; i >= 0; i--) sb.push_back(w[i]);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        sb.push_back(^w);
`endif
    endtask

    // One word from offer to the IDLE cycle after done; cycle 1 is the accept cycle
    task automatic run_word(input logic [SIZE-1:0] w, input int hold_after, input int hold_len,
                            input bit keep_valid, input logic [SIZE-1:0] next_w, input bit expect_now);
        int   waited = 0;
        int   cycle  = 1;
        int   bits   = 0;
        int   held   = 0;
        bit   got_done = 0;
        logic exp_bit;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (in_ready !== 1'b1 || (expect_now && waited != 0)) begin
            bad++;
            $display("FAIL accept_wait: in_ready=%b waited=%0d required in_ready=1 waited=0 (if immediate)", in_ready, waited);
        end
        in_valid = 1'b1;
        in_data  = w;
        push_word(w);
        while (cycle < 60 && !got_done) begin
            @(negedge clk);
            cycle++;
            if (cycle == 2) begin
                total++;
                if (sr_sp !== 1'b0 || sr_en !== 1'b1 || sr_pi !== w) begin
                    bad++;
                    $display("FAIL load: sr_sp=%b sr_en=%b sr_pi=%h required 0 1 %h", sr_sp, sr_en, sr_pi, w);
                end
                if (keep_valid) in_data = next_w;
                else in_valid = 1'b0;
            end
            if (busy) begin
                total++;
                if (in_ready !== 1'b0 || sr_pi !== w) begin
                    bad++;
                    $display("FAIL busy_cycle %0d: in_ready=%b sr_pi=%h required 0 %h", cycle, in_ready, sr_pi, w);
                end
            end
            if (hold) begin
                total++;
                if (ser_valid !== 1'b0 || sr_en !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_cycle %0d: ser_valid=%b sr_en=%b required 0 0", cycle, ser_valid, sr_en);
                end
            end
            if (ser_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL extra_bit cycle %0d: ser_out=%b with empty scoreboard", cycle, ser_out);
                end else begin
                    exp_bit = sb.pop_front();
                    if (ser_out !== exp_bit) begin
                        bad++;
                        $display("FAIL bit %0d of %h: ser_out=%b required %b", bits, w, ser_out, exp_bit);
                    end
                end
                bits++;
            end
            if (done === 1'b1) begin
                got_done = 1;
                total++;
                if (cycle != DONE_CYC + hold_len || sb.size() != 0 || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL done: cycle=%0d left=%0d in_ready=%b required cycle=%0d left=0 in_ready=0",
                             cycle, sb.size(), in_ready, DONE_CYC + hold_len);
                end
            end
            if (hold_len > 0 && bits >= hold_after && held < hold_len) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = 1'b0;
            end
        end
        hold = 1'b0;
        if (!got_done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles for %h", cycle, w);
            sb.delete();
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after: in_ready=%b busy=%b done=%b required 1 0 0", in_ready, busy, done);
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || sr_en !== 1'b0 || done !== 1'b0 ||
            sr_sp !== 1'b1 || ser_valid !== 1'b0) begin
            bad++;
            $display("FAIL in_reset: in_ready=%b busy=%b sr_en=%b done=%b sr_sp=%b ser_valid=%b required 1 0 0 0 1 0",
                     in_ready, busy, sr_en, done, sr_sp, ser_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || sr_en !== 1'b0 || done !== 1'b0 || sr_pi !== 8'h00) begin
            bad++;
            $display("FAIL after_reset: in_ready=%b busy=%b sr_en=%b done=%b sr_pi=%h required 1 0 0 0 00",
                     in_ready, busy, sr_en, done, sr_pi);
        end
    endtask

    task automatic test_basic;
        run_word(8'hA5, 0, 0, 1'b0, 8'h00, 1'b1);
        run_word(8'h07, 0, 0, 1'b0, 8'h00, 1'b1);
        run_word(8'hFF, 0, 0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_hold;
        run_word(8'hA5, 3, 3, 1'b0, 8'h00, 1'b1);
        run_word(8'h5A, 7, 2, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_word(8'hA5, 0, 0, 1'b1, 8'h3C, 1'b1);
        run_word(8'h3C, 0, 0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid;
        int   bits = 0;
        int   guard = 0;
        bit   seen_done = 0;
        logic exp_bit;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        push_word(8'hA5);
        while (bits < 5 && guard < 20) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b0;
            if (ser_valid === 1'b1) begin
                exp_bit = sb.pop_front();
                total++;
                if (ser_out !== exp_bit) begin
                    bad++;
                    $display("FAIL rst_mid_bit %0d: ser_out=%b required %b", bits, ser_out, exp_bit);
                end
                bits++;
            end
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || sr_en !== 1'b0 || in_ready !== 1'b1 || ser_valid !== 1'b0 || bits != 5) begin
            bad++;
            $display("FAIL rst_mid: busy=%b sr_en=%b in_ready=%b ser_valid=%b bits=%0d required 0 0 1 0 5",
                     busy, sr_en, in_ready, ser_valid, bits);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || ser_valid === 1'b1) seen_done = 1;
        end
        total++;
        if (seen_done) begin
            bad++;
            $display("FAIL rst_mid_quiet: activity after reset=%b required 0", seen_done);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        hold     = 1'b0;
        test_reset;
        test_basic;
        test_hold;
        test_back_to_back;
        test_reset_mid;
        run_word(8'hC3, 0, 0, 1'b0, 8'h00, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
